// File: rtl/sprite_ram_writer.sv
// Write side of the robot sprite RAM: parses sprite-frame upload packets from a byte
// stream and drives the sprite sheet write port with 12-bit RGB444 pixels.
module sprite_ram_writer #(
   parameter int unsigned SPRITE_COLS    = 34,
   parameter int unsigned SPRITE_ROWS    = 34,
   parameter int unsigned NUM_FRAME_ROWS = 8,
   parameter int unsigned NUM_FRAME_COLS = 3,
   parameter int unsigned ADDR_WIDTH     = 15,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT        = 1_000_000
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [7:0]                               in_data,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic                                     wr_en,
   output logic [ADDR_WIDTH-1:0]                    wr_addr,
   output logic [11:0]                              wr_data,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     err,
   output logic [NUM_FRAME_ROWS*NUM_FRAME_COLS-1:0] frame_loaded
);

   localparam int unsigned PITCH      = SPRITE_COLS * NUM_FRAME_COLS;
   localparam int unsigned ROW_STRIDE = PITCH * SPRITE_ROWS;
   localparam int unsigned NFRAMES    = NUM_FRAME_ROWS * NUM_FRAME_COLS;
   localparam int XW = $clog2(SPRITE_COLS);
   localparam int YW = $clog2(SPRITE_ROWS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = $clog2(NFRAMES);

   typedef enum logic [2:0] {IDLE, HDR_ROW, HDR_COL, PIX_HI, PIX_LO} state_t;

   state_t                state, next_state;
   logic                  accept;
   logic                  hdr_bad, pix_write, last_col, last_pix, timeout_hit;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [ADDR_WIDTH-1:0] row_ptr;
   logic [3:0]            hi_nib;
   logic [7:0]            frame_row;
   logic [FW-1:0]         frame_idx;
   logic [TW-1:0]         idle_cnt;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Timeout takes priority only when no byte arrives in the expiring cycle.
   always_comb begin
      next_state  = state;
      hdr_bad     = 1'b0;
      pix_write   = 1'b0;
      timeout_hit = 1'b0;
      last_col    = (x == XW'(SPRITE_COLS - 1));
      last_pix    = last_col && (y == YW'(SPRITE_ROWS - 1));
      if ((state != IDLE) && !accept && (idle_cnt == TW'(TIMEOUT - 1))) begin
         timeout_hit = 1'b1;
         next_state  = IDLE;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (in_data == SYNC_BYTE) next_state = HDR_ROW;
               else                      next_state = IDLE;
            end
            HDR_ROW: next_state = HDR_COL;
            HDR_COL: begin
               if ((32'(frame_row) >= NUM_FRAME_ROWS) || (32'(in_data) >= NUM_FRAME_COLS)) begin
                  hdr_bad    = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_state = PIX_HI;
               end
            end
            PIX_HI: next_state = PIX_LO;
            PIX_LO: begin
               pix_write = 1'b1;
               if (last_pix) next_state = IDLE;
               else          next_state = PIX_HI;
            end
            default: next_state = IDLE;
         endcase
      end else begin
         next_state = state;
      end
   end

   // Base address is formed once in the header; pixels then walk x and a row pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready     <= 1'b0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= 12'h000;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         frame_loaded <= '0;
         x            <= '0;
         y            <= '0;
         row_ptr      <= '0;
         hi_nib       <= 4'h0;
         frame_row    <= 8'h00;
         frame_idx    <= '0;
         idle_cnt     <= '0;
      end else begin
         in_ready <= 1'b1;
         wr_en    <= pix_write;
         done     <= pix_write && last_pix;
         err      <= hdr_bad || timeout_hit;
         busy     <= (next_state != IDLE);
         if (pix_write) begin
            wr_addr <= row_ptr + ADDR_WIDTH'(x);
            wr_data <= {hi_nib, in_data};
         end
         if (pix_write && last_pix) frame_loaded[frame_idx] <= 1'b1;
         if (accept || (state == IDLE) || timeout_hit) idle_cnt <= '0;
         else                                           idle_cnt <= idle_cnt + TW'(1);
         if (accept) begin
            case (state)
               HDR_ROW: begin
                  frame_row <= in_data;
                  row_ptr   <= ADDR_WIDTH'(32'(in_data) * ROW_STRIDE);
               end
               HDR_COL: begin
                  row_ptr   <= row_ptr + ADDR_WIDTH'(32'(in_data) * SPRITE_COLS);
                  frame_idx <= FW'(32'(frame_row) * NUM_FRAME_COLS + 32'(in_data));
                  x         <= '0;
                  y         <= '0;
               end
               PIX_HI: hi_nib <= in_data[3:0];
               PIX_LO: begin
                  if (last_col) begin
                     x       <= '0;
                     y       <= y + YW'(1);
                     row_ptr <= row_ptr + ADDR_WIDTH'(PITCH);
                  end else begin
                     x <= x + XW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
